// File: rtl/serial_addr_decoder.sv
// Serial-bus address decoder: shifts in the slave-select field LSB first and
// drives one-hot slave/split selects and a decode-error pulse.
module serial_addr_decoder #(
  parameter int unsigned           NUM_SLAVES = 6,
  parameter int unsigned           SEL_W      = 3,
  parameter logic [NUM_SLAVES-1:0] SPLIT_MASK = NUM_SLAVES'(1)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  B_UTIL,
  input  logic                  A_ADD,
  input  logic                  B_BUS_OUT,
  input  logic [NUM_SLAVES-1:0] B_SBSY,
  output logic [NUM_SLAVES-1:0] AD_SEL,
  output logic [NUM_SLAVES-1:0] SPL_SEL,
  output logic [SEL_W-1:0]      SLAVE_ID,
  output logic                  ADDR_VALID,
  output logic                  DEC_ERR
);

  localparam int unsigned CNT_W      = $clog2(SEL_W + 1);
  localparam bit          SINGLE_BIT = (SEL_W == 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SEL, S_ERR} state_t;

  state_t           r_state;
  state_t           w_next;
  state_t           w_start_next;
  logic [SEL_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_add_d;
  logic [SEL_W-1:0] r_slave_id;

  logic [SEL_W-1:0] w_word;
  logic             w_addr_start;
  logic             w_id_ok;
  logic             w_split_hold;
  logic             w_start_load;
  logic             w_start;
  logic             w_cap;
  logic             w_abort;
  logic             w_id_load;
  logic             w_id_clr;

  assign w_addr_start = B_UTIL & A_ADD & ~r_a_add_d;
  assign w_split_hold = ~B_UTIL & (|(B_SBSY & SPLIT_MASK));

  // Candidate ID: bits already shifted in plus the bit on the bus this cycle
  always_comb begin
    w_word           = r_shift;
    w_word[SEL_W-1]  = B_BUS_OUT;
    w_id_ok          = (w_word != '0) && (w_word <= SEL_W'(NUM_SLAVES));
    w_start_load     = SINGLE_BIT & w_id_ok;
    w_start_next     = S_SHIFT;
    if (SINGLE_BIT) begin
      w_start_next = w_id_ok ? S_SEL : S_ERR;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_cap     = 1'b0;
    w_abort   = 1'b0;
    w_id_load = 1'b0;
    w_id_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_addr_start) begin
          w_start   = 1'b1;
          w_next    = w_start_next;
          w_id_load = w_start_load;
        end
      end
      S_SHIFT: begin
        if (B_UTIL && A_ADD) begin
          w_cap = 1'b1;
          if (r_cnt == CNT_W'(SEL_W - 1)) begin
            w_next    = w_id_ok ? S_SEL : S_ERR;
            w_id_load = w_id_ok;
          end
        end else begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_SEL: begin
        if (w_addr_start) begin
          w_start   = 1'b1;
          w_id_clr  = 1'b1;
          w_next    = w_start_next;
          w_id_load = w_start_load;
        end else if ((B_UTIL && (!A_ADD || r_a_add_d)) || w_split_hold) begin
          w_next = S_SEL;
        end else begin
          w_id_clr = 1'b1;
          w_next   = S_IDLE;
        end
      end
      S_ERR: begin
        if (w_addr_start) begin
          w_start   = 1'b1;
          w_next    = w_start_next;
          w_id_load = w_start_load;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift register, bit counter and held slave ID
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_a_add_d  <= 1'b0;
      r_slave_id <= '0;
    end else begin
      r_a_add_d <= A_ADD;
      if (w_start) begin
        r_shift <= SEL_W'(B_BUS_OUT);
        r_cnt   <= CNT_W'(1);
      end else if (w_cap) begin
        if (r_cnt < CNT_W'(SEL_W)) begin
          r_shift[r_cnt] <= B_BUS_OUT;
          r_cnt          <= r_cnt + CNT_W'(1);
        end
      end else if (w_abort) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end
      if (w_id_load) begin
        r_slave_id <= w_word;
      end else if (w_id_clr) begin
        r_slave_id <= '0;
      end
    end
  end

  // Select decode; a busy split-capable slave is routed to SPL_SEL instead
  always_comb begin
    AD_SEL     = '0;
    SPL_SEL    = '0;
    ADDR_VALID = (r_state == S_SEL);
    DEC_ERR    = (r_state == S_ERR);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if ((r_state == S_SEL) && (r_slave_id == SEL_W'(i + 1))) begin
        if (SPLIT_MASK[i] && B_SBSY[i]) begin
          SPL_SEL[i] = 1'b1;
        end else begin
          AD_SEL[i] = 1'b1;
        end
      end
    end
  end

  assign SLAVE_ID = r_slave_id;

endmodule

// File: tb/tb_serial_addr_decoder.sv
// Directed bench for serial_addr_decoder: decode, split, error, abort,
// back-to-back and asynchronous reset scenarios with fixed expected values.
module tb_serial_addr_decoder;

  logic       CLK;
  logic       RSTN;
  logic       B_UTIL;
  logic       A_ADD;
  logic       B_BUS_OUT;
  logic [5:0] B_SBSY;
  logic [5:0] AD_SEL;
  logic [5:0] SPL_SEL;
  logic [2:0] SLAVE_ID;
  logic       ADDR_VALID;
  logic       DEC_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  serial_addr_decoder #(
    .NUM_SLAVES(6),
    .SEL_W     (3),
    .SPLIT_MASK(6'b000001)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .B_UTIL    (B_UTIL),
    .A_ADD     (A_ADD),
    .B_BUS_OUT (B_BUS_OUT),
    .B_SBSY    (B_SBSY),
    .AD_SEL    (AD_SEL),
    .SPL_SEL   (SPL_SEL),
    .SLAVE_ID  (SLAVE_ID),
    .ADDR_VALID(ADDR_VALID),
    .DEC_ERR   (DEC_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive a 3-bit ID LSB first; nothing may be selected while shifting
  task automatic send_id(input logic [2:0] id);
    logic [2:0] v;
    v = id;
    for (int i = 0; i < 3; i++) begin
      B_UTIL    = 1'b1;
      A_ADD     = 1'b1;
      B_BUS_OUT = v[i];
      tick();
      if (i < 2) begin
        chk("shift_ad_sel", 32'(AD_SEL), 32'd0);
        chk("shift_valid", 32'(ADDR_VALID), 32'd0);
      end
    end
  endtask

  initial begin
    RSTN = 1'b0; B_UTIL = 1'b0; A_ADD = 1'b0; B_BUS_OUT = 1'b0; B_SBSY = 6'b0;
    #12;
    chk("rst_ad_sel", 32'(AD_SEL), 32'd0);
    chk("rst_spl_sel", 32'(SPL_SEL), 32'd0);
    chk("rst_id", 32'(SLAVE_ID), 32'd0);
    chk("rst_valid", 32'(ADDR_VALID), 32'd0);
    chk("rst_err", 32'(DEC_ERR), 32'd0);
    tick();
    RSTN = 1'b1;
    tick();

    // ID 5 = bits 1,0,1
    send_id(3'd5);
    chk("id5_ad_sel", 32'(AD_SEL), 32'h10);
    chk("id5_id", 32'(SLAVE_ID), 32'd5);
    chk("id5_valid", 32'(ADDR_VALID), 32'd1);
    A_ADD = 1'b0;
    tick();
    tick();
    chk("id5_data_ad_sel", 32'(AD_SEL), 32'h10);
    B_SBSY = 6'b010000;
    #1;
    chk("id5_nonsplit_busy_ad", 32'(AD_SEL), 32'h10);
    chk("id5_nonsplit_busy_spl", 32'(SPL_SEL), 32'd0);

    // Asynchronous reset while selected
    RSTN = 1'b0;
    #1;
    chk("arst_ad_sel", 32'(AD_SEL), 32'd0);
    chk("arst_valid", 32'(ADDR_VALID), 32'd0);
    chk("arst_id", 32'(SLAVE_ID), 32'd0);
    B_UTIL = 1'b0; B_SBSY = 6'b0;
    tick();
    RSTN = 1'b1;
    tick();
    chk("arst_idle_valid", 32'(ADDR_VALID), 32'd0);

    // Split: ID 1 with its busy bit set
    B_SBSY = 6'b000001;
    send_id(3'd1);
    chk("split_spl_sel", 32'(SPL_SEL), 32'h01);
    chk("split_ad_sel", 32'(AD_SEL), 32'd0);
    chk("split_valid", 32'(ADDR_VALID), 32'd1);
    B_UTIL = 1'b0; A_ADD = 1'b0;
    tick();
    tick();
    chk("split_hold_spl", 32'(SPL_SEL), 32'h01);
    chk("split_hold_valid", 32'(ADDR_VALID), 32'd1);
    B_SBSY = 6'b0;
    #1;
    chk("split_done_ad_sel", 32'(AD_SEL), 32'h01);
    chk("split_done_spl", 32'(SPL_SEL), 32'd0);
    tick();
    chk("split_release_valid", 32'(ADDR_VALID), 32'd0);
    chk("split_release_id", 32'(SLAVE_ID), 32'd0);

    // Invalid ID 7 = bits 1,1,1
    send_id(3'd7);
    chk("inv_err", 32'(DEC_ERR), 32'd1);
    chk("inv_ad_sel", 32'(AD_SEL), 32'd0);
    chk("inv_valid", 32'(ADDR_VALID), 32'd0);
    B_UTIL = 1'b0; A_ADD = 1'b0;
    tick();
    chk("inv_err_pulse", 32'(DEC_ERR), 32'd0);
    chk("inv_idle_valid", 32'(ADDR_VALID), 32'd0);

    // Abort after two bits, then a fresh ID 4 = bits 0,0,1
    B_UTIL = 1'b1; A_ADD = 1'b1; B_BUS_OUT = 1'b1;
    tick();
    tick();
    A_ADD = 1'b0;
    tick();
    chk("abort_err", 32'(DEC_ERR), 32'd0);
    chk("abort_valid", 32'(ADDR_VALID), 32'd0);
    chk("abort_ad_sel", 32'(AD_SEL), 32'd0);
    send_id(3'd4);
    chk("post_abort_ad_sel", 32'(AD_SEL), 32'h08);
    chk("post_abort_id", 32'(SLAVE_ID), 32'd4);
    B_UTIL = 1'b0; A_ADD = 1'b0;
    tick();
    chk("post_abort_idle", 32'(ADDR_VALID), 32'd0);

    // Back-to-back: ID 2, one data cycle, then ID 3
    send_id(3'd2);
    chk("b2b_id2_ad_sel", 32'(AD_SEL), 32'h02);
    A_ADD = 1'b0;
    tick();
    chk("b2b_data_ad_sel", 32'(AD_SEL), 32'h02);
    send_id(3'd3);
    chk("b2b_id3_ad_sel", 32'(AD_SEL), 32'h04);
    chk("b2b_id3_id", 32'(SLAVE_ID), 32'd3);
    B_BUS_OUT = 1'b1;
    tick();
    tick();
    chk("offset_ad_sel", 32'(AD_SEL), 32'h04);
    chk("offset_valid", 32'(ADDR_VALID), 32'd1);
    chk("offset_err", 32'(DEC_ERR), 32'd0);
    B_UTIL = 1'b0; A_ADD = 1'b0;
    tick();
    chk("final_idle", 32'(ADDR_VALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
